// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-domain stream adapter.
package fifo_pkg;

    localparam int          WIDTH      = 16;
    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] ptr_t;

    function automatic ptr_t ptr_wrap(input ptr_t p);
        return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry circular buffer with push/pop/clear, occupancy and head data.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [width-1:0] head_o,
    output logic             valid_o
);

    logic [width-1:0] mem_q [SKID_DEPTH];
    ptr_t             rd_ptr_q;
    ptr_t             wr_ptr_q;
    logic [1:0]       occ_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_wrap(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_wrap(rd_ptr_q);
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Upstream throttling keeps occ+pend below depth, so a full buffer never sees a push.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && push_i) begin
            assert (occ_q != 2'(SKID_DEPTH));
        end
    end

    always_comb begin
        occ_o   = occ_q;
        head_o  = mem_q[rd_ptr_q];
        valid_o = (occ_q != '0);
    end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain adapter: pops the async FIFO and re-presents words as a valid/ready stream.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int width     = WIDTH,
    parameter int cnt_width = 16
) (
    input  logic                 clk_r,
    input  logic                 reset,
    input  logic                 FIFO_empty,
    input  logic [width-1:0]     data_in,
    output logic                 rd_en,
    input  logic                 flush,
    output logic [width-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [cnt_width-1:0] word_count,
    output logic                 busy
);

    logic                 pend_q;
    logic                 pend_d;
    logic                 discard_q;
    logic                 discard_d;
    logic [cnt_width-1:0] cnt_q;
    logic [cnt_width-1:0] cnt_d;
    logic [1:0]           occ;
    logic                 push;
    logic                 pop;

    stream_skid_buf #(
        .width (width)
    ) u_buf (
        .clk_i       (clk_r),
        .rst_i       (reset),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (data_in),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (out_data),
        .valid_o     (out_valid)
    );

    // Throttle on registered occupancy plus in-flight read only; out_ready never reaches rd_en.
    always_comb begin
        rd_en = ~FIFO_empty & ~flush & ~reset
              & (({1'b0, occ} + {2'b00, pend_q}) < 3'(SKID_DEPTH));
        push  = pend_q & ~discard_q;
        pop   = out_valid & out_ready;
        busy  = (occ != '0) | pend_q;
        word_count = cnt_q;
    end

    always_comb begin
        pend_d    = rd_en;
        // A word in flight at a flush edge is also cleared by the buffer; the flag guards the next cycle.
        discard_d = flush & pend_q;
        cnt_d     = cnt_q;
        if (pop && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_r) begin
        if (reset) begin
            pend_q    <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a FIFO model and expected-word scoreboard.
module tb_fifo_rd_stream_adapter;

    logic        clk_r;
    logic        reset;
    logic        FIFO_empty;
    logic [15:0] data_in;
    logic        rd_en;
    logic        flush;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  word_count;
    logic        busy;

    fifo_rd_stream_adapter #(
        .width     (16),
        .cnt_width (4)
    ) dut (
        .clk_r      (clk_r),
        .reset      (reset),
        .FIFO_empty (FIFO_empty),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count),
        .busy       (busy)
    );

    initial begin
        clk_r = 1'b0;
        forever #5 clk_r = ~clk_r;
    end

    logic [15:0] fifo_q [$];
    logic [15:0] exp_q  [$];
    int          checks = 0;
    int          errors = 0;
    logic        force_empty = 1'b0;
    logic        pend_m = 1'b0;
    logic        hold_m = 1'b0;
    logic [15:0] hold_data = '0;
    logic [3:0]  cnt_m = '0;
    int          cyc = 0;
    int          rd_cnt, ph_deliv, ph_first_rd, ph_first_hs, ph_last_hs;
    logic [15:0] ph_first_data;
    logic [3:0]  saved_cnt;
    logic        done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        FIFO_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic load_fifo(input int base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(16'(base + i));
        upd_empty();
    endtask

    task automatic new_phase();
        rd_cnt = 0; ph_deliv = 0; ph_first_rd = -1; ph_first_hs = -1; ph_last_hs = -1;
        ph_first_data = '0;
    endtask

    // One clock: check at the falling edge, model the FIFO pop, drive data_in after the rising edge.
    task automatic cycle();
        logic        exp_rd;
        logic        pop;
        logic        hs;
        logic [15:0] v;
        @(negedge clk_r);
        exp_rd = !FIFO_empty && !flush && !reset && (exp_q.size() < 3);
        check("rd_en", rd_en, exp_rd);
        check("busy", busy, exp_q.size() != 0);
        check("out_valid", out_valid, (exp_q.size() - int'(pend_m)) != 0);
        check("word_count", word_count, cnt_m);
        if (hold_m) check("out_data_hold", out_data, hold_data);
        hs = out_valid && out_ready && !flush && !reset;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("word_expected", 32'(exp_q.size()), 1);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
            if (cnt_m != 4'hF) cnt_m++;
            if (ph_deliv == 0) begin
                ph_first_hs   = cyc;
                ph_first_data = out_data;
            end
            ph_last_hs = cyc;
            ph_deliv++;
        end
        if (reset) cnt_m = '0;
        hold_m    = out_valid && !out_ready && !flush && !reset;
        hold_data = out_data;
        if (flush || reset) exp_q.delete();
        if (rd_en) begin
            rd_cnt++;
            if (ph_first_rd < 0) ph_first_rd = cyc;
        end
        pop = rd_en && !FIFO_empty;
        v   = '0;
        if (pop) begin
            v = fifo_q.pop_front();
            exp_q.push_back(v);
        end
        pend_m = pop;
        @(posedge clk_r);
        #1;
        data_in = pop ? v : 16'($urandom);
        upd_empty();
        cyc++;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            cycle();
        end
        done = (exp_q.size() == 0) && (fifo_q.size() == 0);
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; data_in = '0;
        load_fifo(1, 8);
        new_phase();

        // Reset held with a non-empty FIFO
        repeat (3) begin
            cycle();
            check("rst_out_data", out_data, 16'h0);
            check("rst_rd_en", rd_en, 1'b0);
        end

        // Streaming at full rate
        reset = 1'b0;
        new_phase();
        repeat (14) cycle();
        check("stream_rd_pulses", rd_cnt, 8);
        check("stream_delivered", ph_deliv, 8);
        check("stream_latency", ph_first_hs - ph_first_rd, 2);
        check("stream_back_to_back", ph_last_hs - ph_first_hs, 7);
        check("stream_count", word_count, 4'd8);

        // Backpressure
        out_ready = 1'b0;
        load_fifo(1, 8);
        new_phase();
        repeat (10) cycle();
        check("bp_rd_pulses", rd_cnt, 3);
        check("bp_valid", out_valid, 1'b1);
        check("bp_head", out_data, 16'd1);
        out_ready = 1'b1;
        drain(40);
        check("bp_delivered", ph_deliv, 8);

        // FIFO_empty toggling every other cycle
        load_fifo(1, 8);
        new_phase();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
            force_empty = ~force_empty;
            upd_empty();
            cycle();
        end
        force_empty = 1'b0;
        upd_empty();
        check("empty_delivered", ph_deliv, 8);
        repeat (2) cycle();
        check("empty_busy_idle", busy, 1'b0);

        // Flush with two buffered words and one in flight
        out_ready = 1'b0;
        load_fifo(9, 8);
        new_phase();
        repeat (3) cycle();
        check("pre_flush_valid", out_valid, 1'b1);
        saved_cnt = word_count;
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("post_flush_valid", out_valid, 1'b0);
        check("post_flush_busy", busy, 1'b0);
        check("flush_count_kept", word_count, saved_cnt);
        drain(40);
        check("flush_next_word", ph_first_data, 16'd12);
        check("flush_delivered", ph_deliv, 5);

        // Counter saturation
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        load_fifo(1, 20);
        new_phase();
        drain(80);
        check("sat_delivered", ph_deliv, 20);
        check("sat_count", word_count, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
